// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the exhaustive gate sweep checker.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned MAX_N_IN = 8;

    // Reference truth tables for common 3-input gates; bit i is y for input code i.
    localparam logic [7:0] EXP_TT_AND3 = 8'h80;
    localparam logic [7:0] EXP_TT_OR3  = 8'hFE;
    localparam logic [7:0] EXP_TT_XOR3 = 8'h96;

endpackage

// File: rtl/gate_sweep_timer.sv
// Loadable settle down-counter; holds at zero and flags it combinationally.
module gate_sweep_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus engine and checker for an N-input single-output gate.
// Optional build macro GATE_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int unsigned          N_IN       = 3,
    parameter int unsigned          SETTLE_CYC = 4,
    parameter logic [(2**N_IN)-1:0] EXP_TT     = EXP_TT_AND3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_y,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int unsigned     ERR_W    = N_IN + 1;
    localparam int unsigned     CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_vec;
    logic [N_IN-1:0]   w_vec_nxt;
    logic [ERR_W-1:0]  r_err;
    logic [ERR_W-1:0]  w_err_nxt;
    logic [N_IN-1:0]   r_fev;
    logic [N_IN-1:0]   w_fev_nxt;
    logic              r_fev_vld;
    logic              w_fev_vld_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_pass;
    logic              w_pass_nxt;
    logic              w_tmr_load;
    logic              w_tmr_dec;
    logic              w_tmr_zero;
    logic              w_mismatch;
    logic              w_last;

    gate_sweep_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (RELOAD),
        .i_dec      (w_tmr_dec),
        .o_zero_c   (w_tmr_zero)
    );

    assign w_mismatch = (dut_y != EXP_TT[r_vec]);

    // Next-state and next-result logic
    always_comb begin
        w_state_nxt   = r_state;
        w_vec_nxt     = r_vec;
        w_err_nxt     = r_err;
        w_fev_nxt     = r_fev;
        w_fev_vld_nxt = r_fev_vld;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_pass_nxt    = r_pass;
        w_tmr_load    = 1'b0;
        w_tmr_dec     = 1'b0;
        w_last        = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt   = ST_SETTLE;
                    w_vec_nxt     = '0;
                    w_err_nxt     = '0;
                    w_fev_nxt     = '0;
                    w_fev_vld_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_pass_nxt    = 1'b0;
                    w_tmr_load    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err + ERR_W'(1);
                    if (!r_fev_vld) begin
                        w_fev_nxt     = r_vec;
                        w_fev_vld_nxt = 1'b1;
                    end
                end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
                w_last = (r_vec == VEC_LAST) || w_mismatch;
`else
                w_last = (r_vec == VEC_LAST);
`endif
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_nxt == '0);
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_vec_nxt   = r_vec + N_IN'(1);
                    w_tmr_load  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vec     <= '0;
            r_err     <= '0;
            r_fev     <= '0;
            r_fev_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vec     <= w_vec_nxt;
            r_err     <= w_err_nxt;
            r_fev     <= w_fev_nxt;
            r_fev_vld <= w_fev_vld_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
        end
    end

    assign vec_out         = r_vec;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_cnt         = r_err;
    assign first_err_vec   = r_fev;
    assign first_err_valid = r_fev_vld;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: an AND3 and an XOR4 instance driven by modelled gates.
module tb_gate_sweep_checker;

    localparam int S   = 4;
    localparam int PER = S + 1;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    logic y0, y1;

    logic [2:0] vec0;  logic busy0, done0, pass0;  logic [3:0] err0;  logic [2:0] fev0;  logic fv0;
    logic [3:0] vec1;  logic busy1, done1, pass1;  logic [4:0] err1;  logic [3:0] fev1;  logic fv1;

    always #5 clk = ~clk;

    gate_sweep_checker #(.N_IN(3), .SETTLE_CYC(S), .EXP_TT(8'h80)) u_and3 (
        .clk(clk), .rst(rst), .start(start0), .dut_y(y0), .vec_out(vec0), .busy(busy0),
        .done(done0), .pass(pass0), .err_cnt(err0), .first_err_vec(fev0), .first_err_valid(fv0)
    );

    gate_sweep_checker #(.N_IN(4), .SETTLE_CYC(S), .EXP_TT(16'h6996)) u_xor4 (
        .clk(clk), .rst(rst), .start(start1), .dut_y(y1), .vec_out(vec1), .busy(busy1),
        .done(done1), .pass(pass1), .err_cnt(err1), .first_err_vec(fev1), .first_err_valid(fv1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model state, one slot per instance
    logic [15:0] ytab[2];
    logic [15:0] mm_next[2];
    logic [15:0] mm[2];
    bit          act[2];
    int          t[2];
    int          tend[2];
    logic        glit[2];
    logic        gen[2];

    function automatic int nbits(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    function automatic bit spec_gate(input int d, input int v);
        logic [3:0] b;
        b = 4'(v);
        if (d == 0) return b[0] & b[1] & b[2];
        return b[0] ^ b[1] ^ b[2] ^ b[3];
    endfunction

    function automatic int sweep_len(input int d, input logic [15:0] m);
        int nv;
        nv = 1 << nbits(d);
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        for (int v = 0; v < nv; v++) if (m[v]) return (v + 1) * PER;
`else
        if (m == 16'hFFFF) return nv * PER;
`endif
        return nv * PER;
    endfunction

    // Expected outputs as a function of cycles elapsed since the accepted start
    function automatic void model_out(input bit a, input int tt, input int te, input logic [15:0] m,
                                      output int ev, output int eb, output int ed, output int ep,
                                      output int ec, output int ef, output int efv);
        int chkd;
        ev = 0; eb = 0; ed = 0; ep = 0; ec = 0; ef = 0; efv = 0;
        if (!a) return;
        chkd = (tt >= te) ? te / PER : tt / PER;
        for (int v = 0; v < chkd; v++) begin
            if (m[v]) begin
                if (efv == 0) begin ef = v; efv = 1; end
                ec++;
            end
        end
        if (tt >= te) begin
            ev = te / PER - 1; ed = 1; ep = (ec == 0) ? 1 : 0;
        end else begin
            ev = tt / PER; eb = 1;
        end
    endfunction

    task automatic chk(input string name, input int actual, input int expected);
        n_chk++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (time %0t)", name, actual, expected, $time);
    endtask

    always_comb begin
        for (int d = 0; d < 2; d++)
            gen[d] = act[d] && (t[d] < tend[d]) && ((t[d] % PER) != S);
    end

    assign y0 = ytab[0][vec0] ^ (glit[0] & gen[0]);
    assign y1 = ytab[1][vec1] ^ (glit[1] & gen[1]);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                act[d] <= 1'b0;
                t[d]   <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (((d == 0) ? start0 : start1) && !(act[d] && t[d] < tend[d])) begin
                    act[d]  <= 1'b1;
                    t[d]    <= 0;
                    mm[d]   <= mm_next[d];
                    tend[d] <= sweep_len(d, mm_next[d]);
                end else if (act[d] && t[d] < 1000000) begin
                    t[d] <= t[d] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        int ev, eb, ed, ep, ec, ef, efv;
        int av[7];
        for (int d = 0; d < 2; d++) begin
            model_out(act[d], t[d], tend[d], mm[d], ev, eb, ed, ep, ec, ef, efv);
            if (d == 0) av = '{int'(vec0), int'(busy0), int'(done0), int'(pass0), int'(err0), int'(fev0), int'(fv0)};
            else        av = '{int'(vec1), int'(busy1), int'(done1), int'(pass1), int'(err1), int'(fev1), int'(fv1)};
            chk($sformatf("d%0d t=%0d vec_out", d, t[d]), av[0], ev);
            chk($sformatf("d%0d t=%0d busy", d, t[d]), av[1], eb);
            chk($sformatf("d%0d t=%0d done", d, t[d]), av[2], ed);
            chk($sformatf("d%0d t=%0d pass", d, t[d]), av[3], ep);
            chk($sformatf("d%0d t=%0d err_cnt", d, t[d]), av[4], ec);
            chk($sformatf("d%0d t=%0d first_err_vec", d, t[d]), av[5], ef);
            chk($sformatf("d%0d t=%0d first_err_valid", d, t[d]), av[6], efv);
        end
    end

    // mode: 0 correct gate, 1 tied 0, 2 tied 1, 3 random table
    task automatic setup(input int d, input int md);
        logic [15:0] rnd, yt, mt;
        rnd = 16'($urandom);
        yt = '0; mt = '0;
        for (int v = 0; v < (1 << nbits(d)); v++) begin
            case (md)
                0:       yt[v] = spec_gate(d, v);
                1:       yt[v] = 1'b0;
                2:       yt[v] = 1'b1;
                default: yt[v] = rnd[v];
            endcase
            mt[v] = (yt[v] != spec_gate(d, v));
        end
        ytab[d]    = yt;
        mm_next[d] = mt;
    endtask

    task automatic pulse_start(input bit s0, input bit s1);
        @(negedge clk);
        start0 = s0; start1 = s1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
    endtask

    initial begin
        glit[0] = 1'b0; glit[1] = 1'b0;
        forever begin
            @(negedge clk);
            glit[0] = 1'($urandom); glit[1] = 1'($urandom);
        end
    end

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tend[d] = 0; mm[d] = '0; act[d] = 1'b0; t[d] = 0;
        end
        setup(0, 0); setup(1, 0);
        repeat (3) @(negedge clk);
        chk("reset_vec_out", int'(vec0), 0);
        chk("reset_done", int'(done0), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Correct AND3 and XOR4: exact done cycles and pass
        pulse_start(1'b1, 1'b1);
        repeat (39) @(negedge clk);
        chk("and3_done_at_39", int'(done0), 0);
        @(negedge clk);
        chk("and3_done_at_40", int'(done0), 1);
        chk("and3_pass", int'(pass0), 1);
        chk("and3_err_cnt", int'(err0), 0);
        chk("and3_first_err_valid", int'(fv0), 0);
        repeat (39) @(negedge clk);
        chk("xor4_done_at_79", int'(done1), 0);
        @(negedge clk);
        chk("xor4_done_at_80", int'(done1), 1);
        chk("xor4_pass", int'(pass1), 1);

        // AND3 with output stuck at 0: only code 7 fails
        setup(0, 1);
        pulse_start(1'b1, 1'b0);
        repeat (42) @(negedge clk);
        chk("tied0_err_cnt", int'(err0), 1);
        chk("tied0_first_err_vec", int'(fev0), 7);
        chk("tied0_first_err_valid", int'(fv0), 1);
        chk("tied0_pass", int'(pass0), 0);

        // AND3 with output stuck at 1
        setup(0, 2);
        pulse_start(1'b1, 1'b0);
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        repeat (5) @(negedge clk);
        chk("stop_done_at_5", int'(done0), 1);
        chk("stop_vec_out", int'(vec0), 0);
        chk("stop_err_cnt", int'(err0), 1);
        chk("stop_first_err_vec", int'(fev0), 0);
        chk("stop_pass", int'(pass0), 0);
        repeat (37) @(negedge clk);
`else
        repeat (42) @(negedge clk);
        chk("tied1_err_cnt", int'(err0), 7);
        chk("tied1_first_err_vec", int'(fev0), 0);
        chk("tied1_pass", int'(pass0), 0);
`endif

        // Start in DONE clears results and restarts at code 0
        pulse_start(1'b1, 1'b0);
        chk("restart_done_cleared", int'(done0), 0);
        chk("restart_err_cleared", int'(err0), 0);
        chk("restart_vec_out", int'(vec0), 0);
        chk("restart_busy", int'(busy0), 1);
        repeat (42) @(negedge clk);

        // Reset mid-sweep, then a clean sweep
        setup(0, 0); setup(1, 0);
        pulse_start(1'b1, 1'b1);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_vec_out", int'(vec0), 0);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_xor4_vec_out", int'(vec1), 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start(1'b1, 1'b0);
        repeat (40) @(negedge clk);
        chk("post_rst_pass", int'(pass0), 1);

        // Start re-pulsed while busy is ignored
        pulse_start(1'b1, 1'b0);
        repeat (9) @(negedge clk);
        pulse_start(1'b1, 1'b0);
        repeat (28) @(negedge clk);
        chk("repulse_done_at_39", int'(done0), 0);
        @(negedge clk);
        chk("repulse_done_at_40", int'(done0), 1);
        repeat (2) @(negedge clk);

        // Random gate behaviour with settle-window glitches
        for (int i = 0; i < 14; i++) begin
            setup(0, int'($urandom_range(0, 3)));
            setup(1, int'($urandom_range(0, 3)));
            pulse_start(1'b1, 1'b1);
            repeat (82 + int'($urandom_range(0, 3))) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
